// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner: synchronise, debounce, press/release
// pulses and hold-to-repeat pulses. Channels are fully independent; only the
// clock and reset are shared.

module button_channel #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    input  logic repeat_en,
    output logic clean,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

    logic             s1, s2;
    logic [CNT_W-1:0] dcnt, rcnt, rcnt_nxt;
    rstate_t          state, state_nxt;
    logic             flip, rise, fall, tick;

    // clean flips on the sample that completes a full run of disagreement
    assign flip = (s2 != clean) && (dcnt == D_LAST);
    assign rise = flip && s2;
    assign fall = flip && !s2;

    // two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= noisy;
            s2 <= s1;
        end
    end

    // debounce: count consecutive disagreeing samples, any agreement restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean <= 1'b0;
            dcnt  <= '0;
        end else if (s2 != clean) begin
            if (dcnt == D_LAST) begin
                clean <= s2;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end else begin
            dcnt <= '0;
        end
    end

    // registered pulses; press always yields a repeat pulse, timed ones only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            press <= rise;
            rel   <= fall;
            rpt   <= rise || tick;
        end
    end

    // repeat FSM state and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // repeat FSM next state: release or disable takes priority over a due repeat
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        tick      = 1'b0;
        if (fall || !repeat_en) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // fresh press, or enable raised while already held
                    if (rise || clean) begin
                        state_nxt = DELAY;
                        rcnt_nxt  = '0;
                    end
                end
                DELAY: begin
                    if (rcnt == DLY_LAST) begin
                        tick      = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = REPEAT;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt == PER_LAST) begin
                        tick     = 1'b1;
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end
endmodule

module button_conditioner #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [N_CH-1:0] repeat_en_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] press_out,
    output logic [N_CH-1:0] release_out,
    output logic [N_CH-1:0] repeat_out
);
    localparam int MAX_SR = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_SR > REPEAT_PERIOD) ? MAX_SR : REPEAT_PERIOD;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        button_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk      (clk_in),
            .rst_n    (rst_n_in),
            .noisy    (noisy_in[c]),
            .repeat_en(repeat_en_in[c]),
            .clean    (clean_out[c]),
            .press    (press_out[c]),
            .rel      (release_out[c]),
            .rpt      (repeat_out[c])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (2 channels, STABLE=4, DELAY=10, PERIOD=3).
// Stimulus is an edge-indexed table: sn[k]/se[k] are the levels sampled at
// run edge k, and lX[k] are the outputs seen just after run edge k.

module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] noisy = 2'b00;
    logic [1:0] en = 2'b00;
    logic [1:0] clean, press, rel, rpt;

    int vectors = 0;
    int errs = 0;

    logic [1:0] sn [0:127];
    logic [1:0] se [0:127];
    logic [1:0] lc [0:127];
    logic [1:0] lp [0:127];
    logic [1:0] lr [0:127];
    logic [1:0] lq [0:127];

    button_conditioner #(
        .N_CH(2), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .noisy_in    (noisy),
        .repeat_en_in(en),
        .clean_out   (clean),
        .press_out   (press),
        .release_out (rel),
        .repeat_out  (rpt)
    );

    always #5 clk = ~clk;

    task automatic fill(input int a, input int b, input logic [1:0] n, input logic [1:0] e);
        for (int k = a; k <= b; k++) begin
            sn[k] = n;
            se[k] = e;
        end
    endtask

    task automatic run(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            noisy = sn[k];
            en    = se[k];
            @(posedge clk);
            #1;
            lc[k] = clean;
            lp[k] = press;
            lr[k] = rel;
            lq[k] = rpt;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        noisy = 2'b00;
        en    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        noisy = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clean, press, rel, rpt} !== 8'h00) begin
            errs++;
            $display("FAIL reset_async got=%h exp=00", {clean, press, rel, rpt});
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({clean, press, rel, rpt} !== 8'h00) begin
            errs++;
            $display("FAIL reset_held got=%h exp=00", {clean, press, rel, rpt});
        end
        rst_n = 1'b1;
        fill(0, 9, 2'b11, 2'b00);
        run(8);
        vectors++;
        if (lc[4] !== 2'b00) begin errs++; $display("FAIL reset_clean_e4 got=%b exp=00", lc[4]); end
        vectors++;
        if (lc[5] !== 2'b11) begin errs++; $display("FAIL reset_clean_e5 got=%b exp=11", lc[5]); end
        vectors++;
        if (lp[5] !== 2'b11) begin errs++; $display("FAIL reset_press_e5 got=%b exp=11", lp[5]); end
        vectors++;
        if (lp[6] !== 2'b00) begin errs++; $display("FAIL reset_press_e6 got=%b exp=00", lp[6]); end
        vectors++;
        if (lq[5] !== 2'b11) begin errs++; $display("FAIL reset_rpt_e5 got=%b exp=11", lq[5]); end
        // mid-hold reset: outputs drop at once, no release pulse
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clean, press, rel, rpt} !== 8'h00) begin
            errs++;
            $display("FAIL reset_midhold got=%h exp=00", {clean, press, rel, rpt});
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rel !== 2'b00) begin errs++; $display("FAIL reset_no_release got=%b exp=00", rel); end
    endtask

    task automatic test_press_release();
        int np, nr, nq;
        do_reset();
        fill(0, 19, 2'b01, 2'b00);
        fill(20, 31, 2'b00, 2'b00);
        run(30);
        vectors++;
        if (lc[4] !== 2'b00) begin errs++; $display("FAIL pr_clean_e4 got=%b exp=00", lc[4]); end
        vectors++;
        if (lc[5] !== 2'b01) begin errs++; $display("FAIL pr_clean_e5 got=%b exp=01", lc[5]); end
        vectors++;
        if (lp[5] !== 2'b01 || lq[5] !== 2'b01) begin
            errs++; $display("FAIL pr_press_e5 got=%b/%b exp=01/01", lp[5], lq[5]);
        end
        vectors++;
        if (lc[24] !== 2'b01 || lc[25] !== 2'b00) begin
            errs++; $display("FAIL pr_fall got=%b,%b exp=01,00", lc[24], lc[25]);
        end
        vectors++;
        if (lr[25] !== 2'b01 || lr[26] !== 2'b00) begin
            errs++; $display("FAIL pr_release got=%b,%b exp=01,00", lr[25], lr[26]);
        end
        np = 0; nr = 0; nq = 0;
        for (int k = 0; k < 30; k++) begin
            np += int'(lp[k][0]);
            nr += int'(lr[k][0]);
            nq += int'(lq[k][0]);
        end
        vectors++;
        if (np != 1 || nr != 1 || nq != 1) begin
            errs++; $display("FAIL pr_pulse_counts got=%0d/%0d/%0d exp=1/1/1", np, nr, nq);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        fill(0, 2, 2'b01, 2'b00);
        fill(3, 3, 2'b00, 2'b00);
        fill(4, 6, 2'b01, 2'b00);
        fill(7, 19, 2'b00, 2'b00);
        run(20);
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if ({lc[k][0], lp[k][0], lr[k][0], lq[k][0]} !== 4'b0000) begin
                errs++;
                $display("FAIL bounce_quiet k=%0d got=%b exp=0000", k,
                         {lc[k][0], lp[k][0], lr[k][0], lq[k][0]});
            end
        end
        do_reset();
        fill(0, 2, 2'b01, 2'b00);
        fill(3, 3, 2'b00, 2'b00);
        fill(4, 19, 2'b01, 2'b00);
        run(12);
        vectors++;
        if (lc[8][0] !== 1'b0 || lc[9][0] !== 1'b1) begin
            errs++; $display("FAIL bounce_settle got=%b,%b exp=0,1", lc[8][0], lc[9][0]);
        end
        vectors++;
        if (lp[9][0] !== 1'b1 || lp[4][0] !== 1'b0) begin
            errs++; $display("FAIL bounce_press got=%b,%b exp=1,0", lp[9][0], lp[4][0]);
        end
    endtask

    task automatic test_auto_repeat();
        logic e;
        do_reset();
        fill(0, 39, 2'b01, 2'b01);
        run(30);
        for (int k = 0; k < 30; k++) begin
            e = (k == 5 || k == 15 || k == 18 || k == 21 || k == 24 || k == 27);
            vectors++;
            if (lq[k][0] !== e) begin
                errs++; $display("FAIL repeat_on k=%0d got=%b exp=%b", k, lq[k][0], e);
            end
        end
        do_reset();
        fill(0, 39, 2'b01, 2'b00);
        run(30);
        for (int k = 0; k < 30; k++) begin
            e = (k == 5);
            vectors++;
            if (lq[k][0] !== e) begin
                errs++; $display("FAIL repeat_off k=%0d got=%b exp=%b", k, lq[k][0], e);
            end
        end
    endtask

    task automatic test_boundaries();
        logic e;
        // release lands on the edge of the P+13 repeat
        do_reset();
        fill(0, 12, 2'b01, 2'b01);
        fill(13, 39, 2'b00, 2'b01);
        run(25);
        vectors++;
        if (lq[15][0] !== 1'b1) begin errs++; $display("FAIL coinc_rpt_p10 got=%b exp=1", lq[15][0]); end
        vectors++;
        if (lc[17][0] !== 1'b1 || lc[18][0] !== 1'b0) begin
            errs++; $display("FAIL coinc_fall got=%b,%b exp=1,0", lc[17][0], lc[18][0]);
        end
        vectors++;
        if (lr[18][0] !== 1'b1 || lq[18][0] !== 1'b0) begin
            errs++; $display("FAIL coinc_release_wins rel=%b rpt=%b exp=1,0", lr[18][0], lq[18][0]);
        end
        vectors++;
        if (lq[21][0] !== 1'b0) begin errs++; $display("FAIL coinc_no_more got=%b exp=0", lq[21][0]); end
        // enable dropped at edge P+5, raised again at edge P+7
        do_reset();
        fill(0, 9, 2'b01, 2'b01);
        fill(10, 11, 2'b01, 2'b00);
        fill(12, 39, 2'b01, 2'b01);
        run(28);
        for (int k = 0; k < 28; k++) begin
            e = (k == 5 || k == 22 || k == 25);
            vectors++;
            if (lq[k][0] !== e) begin
                errs++; $display("FAIL enable_gap k=%0d got=%b exp=%b", k, lq[k][0], e);
            end
        end
    endtask

    task automatic test_independence();
        logic e;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            sn[k] = {(k % 4) != 3, 1'b1};
            se[k] = 2'b01;
        end
        run(30);
        for (int k = 0; k < 30; k++) begin
            e = (k == 5 || k == 15 || k == 18 || k == 21 || k == 24 || k == 27);
            vectors++;
            if (lq[k][0] !== e || {lc[k][1], lp[k][1], lr[k][1], lq[k][1]} !== 4'b0000) begin
                errs++;
                $display("FAIL indep k=%0d ch0_rpt=%b exp=%b ch1=%b exp=0000", k, lq[k][0], e,
                         {lc[k][1], lp[k][1], lr[k][1], lq[k][1]});
            end
        end
    endtask

    task automatic test_reset_midhold();
        do_reset();
        fill(0, 39, 2'b01, 2'b01);
        run(17);
        vectors++;
        if (lq[15][0] !== 1'b1) begin errs++; $display("FAIL midhold_rpt_p10 got=%b exp=1", lq[15][0]); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clean, press, rel, rpt} !== 8'h00) begin
            errs++; $display("FAIL midhold_drop got=%h exp=00", {clean, press, rel, rpt});
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rel !== 2'b00) begin errs++; $display("FAIL midhold_no_release got=%b exp=00", rel); end
        rst_n = 1'b1;
        run(8);
        vectors++;
        if (lc[4] !== 2'b00 || lc[5] !== 2'b01) begin
            errs++; $display("FAIL midhold_repress got=%b,%b exp=00,01", lc[4], lc[5]);
        end
        vectors++;
        if (lp[5] !== 2'b01 || lq[5] !== 2'b01 || lr[5] !== 2'b00) begin
            errs++; $display("FAIL midhold_press got=%b/%b/%b exp=01/01/00", lp[5], lq[5], lr[5]);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_auto_repeat();
        test_boundaries();
        test_independence();
        test_reset_midhold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel pushbutton conditioner. It replaces the per-button debounce instances on the game board. Each channel synchronises a raw button, debounces it, emits one-cycle press and release pulses, and optionally generates hold-to-repeat pulses. `game_logic` and menu navigation consume these pulses instead of raw levels.

## Interface
Parameters:
- `N_CH`, 5: number of independent button channels.
- `STABLE_CYCLES`, 1_000_000: consecutive disagreeing samples required before `clean_out` flips. Must be ≥1.
- `REPEAT_DELAY`, 12_500_000: cycles from press to first timed repeat. Must be ≥1.
- `REPEAT_PERIOD`, 2_500_000: cycles between subsequent timed repeats. Must be ≥1.
- Derived `CNT_W` = $clog2(max(`STABLE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`) + 1). Used for all counters.

Ports:
- `clk_in`, input, 1: system clock. One clock domain.
- `rst_n_in`, input, 1: reset, asynchronous, active-low.
- `noisy_in`, input, `N_CH`: raw asynchronous button levels.
- `repeat_en_in`, input, `N_CH`: per-channel auto-repeat enable (synchronous).
- `clean_out`, output, `N_CH`: debounced level.
- `press_out`, output, `N_CH`: one-cycle pulse on rising `clean_out`.
- `release_out`, output, `N_CH`: one-cycle pulse on falling `clean_out`.
- `repeat_out`, output, `N_CH`: one-cycle pulse on press, plus timed repeats while held.

## Operation
- **Synchroniser:** each channel passes `noisy_in` through a 2-flop synchroniser (`s1` → `s2`). Both flops reset to 0.
- **Debounce counter:** per channel, on each edge:
  - if `s2` != `clean_out`, increment `dcnt`;
  - when `dcnt` == `STABLE_CYCLES`-1 while disagreeing, set `clean_out` <= `s2` and `dcnt` <= 0;
  - if `s2` == `clean_out`, `dcnt` <= 0.
  - Any single agreeing sample restarts the count.
- **Pulses:** all outputs are registered.
  - `press_out` is high exactly during the first cycle `clean_out` reads 1.
  - `release_out` is high exactly during the first cycle `clean_out` reads 0 after being 1.
- **Repeat FSM:** per channel, states IDLE, DELAY, REPEAT, with counter `rcnt`.
  - IDLE → DELAY on press when `repeat_en_in`=1, `rcnt` <= 0.
  - DELAY: `rcnt` increments. When `rcnt` == `REPEAT_DELAY`-1, pulse `repeat_out`, `rcnt` <= 0, go to REPEAT.
  - REPEAT: `rcnt` increments. When `rcnt` == `REPEAT_PERIOD`-1, pulse `repeat_out` and set `rcnt` <= 0.
  - Any state → IDLE, `rcnt` <= 0, when `clean_out` falls or `repeat_en_in`=0.
  - IDLE → DELAY (no immediate pulse) if `repeat_en_in` rises while `clean_out`=1.
- **`repeat_out` sources:** `repeat_out` pulses on press regardless of `repeat_en_in`. Timed pulses occur only when enabled.
- **Channel independence:** channels share nothing but clock and reset.

## Timing
- **Reset:** all outputs are 0 asynchronously while `rst_n_in`=0, and all counters and FSMs are cleared. The conditioner does not preload from `noisy_in`: a button held through reset produces a press `STABLE_CYCLES`+1 edges after deassertion.
- **Debounce latency:** `noisy_in` is captured into `s1` at edge 0 and held. `clean_out` changes at edge `STABLE_CYCLES`+1, with `press_out`/`release_out` high for the following cycle only.
- **Repeat schedule:** with press cycle P (first cycle `clean_out`=1), `repeat_out` is high in cycles P, P+`REPEAT_DELAY`, then P+`REPEAT_DELAY`+k·`REPEAT_PERIOD`, k≥1, while held and enabled.
- **Simultaneous events:**
  - Release and a due repeat in the same edge: release wins, no repeat pulse.
  - `repeat_en_in` dropping on the edge a repeat is due: no repeat pulse.
- **Glitches and reset:**
  - Glitch shorter than `STABLE_CYCLES` (at `s2`): no output activity.
  - Reset asserted mid-hold: outputs drop immediately, with no release pulse.
- **Counter widths:** counters never exceed their compare value, so no wrap-around is possible.

## Test plan
Parameters: `N_CH`=2, `STABLE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
1. **Reset values:** assert `rst_n_in`=0 mid-clock with `noisy_in`=2'b11 → all outputs 0 without waiting for an edge. After deassertion, `clean_out`=2'b11 at edge 5 and `press_out`=2'b11 for one cycle.
2. **Clean press and release:** `noisy_in[0]` 0→1 captured at edge 0 → `clean_out[0]` rises at edge 5, `press_out[0]` and `repeat_out[0]` high one cycle. Drop the input → `clean_out[0]` falls 5 edges later and `release_out[0]` pulses once.
3. **Bounce rejection:** high for 3 cycles, low 1, high 3, low → `clean_out[0]` stays 0 and no pulses. High 3, low 1, then held high → the rise occurs 5 edges after the final rise.
4. **Auto-repeat:** `repeat_en_in[0]`=1, hold for 25 cycles past P → `repeat_out[0]` high at P, P+10, P+13, P+16, P+19, P+22 only. With `repeat_en_in[0]`=0 → only P.
5. **Boundaries:**
   - Release timed to coincide with the P+13 repeat → `release_out` pulses and `repeat_out` does not.
   - Deassert enable at P+5, reassert at P+7 → next repeat at P+17.
6. **Independence and reset mid-hold:**
   - Channel 1 bouncing while channel 0 is held → channel 0 repeat schedule unchanged.
   - Reset asserted at P+11 → outputs 0 with no `release_out`. After deassertion with the button still held, a fresh press occurs 5 edges later.
